// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU op encodings, FSM states
// and the legal-op check used by the ALU wrapper.
package alu_share_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_alu.sv
// The team's N-bit ALU: add/sub/and/or, purely combinational.
// Unsupported op encodings produce a zero result and raise illegal.
module alu_share_alu
  import alu_share_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         illegal
);

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a + ~b + N'(1);
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first set request at or after
// ptr (wrapping), returning a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] id,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  int             sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    grant = '0;
    id    = '0;
    any   = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      sum = int'(ptr) + off;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      idx = IDW'(sum);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one N-bit ALU between NREQ requesters with round-robin arbitration,
// valid/ready handshakes and a fixed two-cycle accept-to-response latency.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_op,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [3:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            arb_en;
  logic [3:0]      sel_op;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic [N-1:0]    alu_result;
  logic            alu_illegal;
  logic [NREQ-1:0] id_onehot;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .id    (grant_id),
    .any   (grant_any)
  );

  alu_share_alu #(
    .N (N)
  ) u_alu (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[N*i +: N];
        sel_b  = req_b[N*i +: N];
      end
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      id_onehot[i] = (id_q == IDW'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    rsp_valid_d = rsp_valid_q;
    arb_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
      end
      ST_EXEC: begin
        result_d    = alu_result;
        zero_d      = (alu_result == '0);
        illegal_d   = alu_illegal;
        rsp_valid_d = id_onehot;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // A consumed response frees the ALU for a same-cycle accept.
        if (rsp_ready) begin
          arb_en      = 1'b1;
          rsp_valid_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb_en && grant_any) begin
      id_d     = grant_id;
      op_d     = sel_op;
      a_d      = sel_a;
      b_d      = sel_b;
      rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      state_d  = ST_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready   = arb_en ? grant : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized plus directed bench for alu_share_arbiter, checked against a
// transaction-level model (pending-op queue, accept timestamps, RR pointer).
module tb_alu_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;

  alu_share_arbiter #(
    .N    (N),
    .NREQ (NREQ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
  } item_t;

  item_t pend[$];
  int    ptr;
  int    cyc;
  int    total;
  int    bad;

  int          obs_id[$];
  int          obs_cyc[$];
  logic [31:0] last_res;
  logic        last_zero;
  logic        last_ill;
  logic [1:0]  last_valid;
  int          rsp_seen;

  // Checking task: counts every comparison and reports a mismatch
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] aluModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic isLegal(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b0110) || (op == 4'b0000) || (op == 4'b0001);
  endfunction

  // Reference model for one clock: compare sampled outputs, then advance
  task automatic modelCycle();
    logic [1:0]  exp_valid;
    logic [1:0]  exp_ready;
    logic [31:0] er;
    bit          inflight;
    bit          in_resp;
    bit          can_acc;
    int          g;
    item_t       it;

    inflight  = (pend.size() != 0);
    in_resp   = inflight && (cyc >= pend[0].acc + 2);
    exp_valid = '0;
    if (in_resp) begin
      exp_valid[pend[0].id] = 1'b1;
      er = aluModel(pend[0].op, pend[0].a, pend[0].b);
      checkOutput("rsp_result", 64'(rsp_result), 64'(er));
      checkOutput("rsp_zero", 64'(rsp_zero), 64'(er == 32'd0));
      checkOutput("rsp_illegal", 64'(rsp_illegal), 64'(!isLegal(pend[0].op)));
    end
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));

    if (rsp_valid != 2'b00) begin
      last_res   = rsp_result;
      last_zero  = rsp_zero;
      last_ill   = rsp_illegal;
      last_valid = rsp_valid;
      rsp_seen++;
    end

    can_acc   = !inflight || (in_resp && rsp_ready);
    g         = -1;
    exp_ready = '0;
    if (can_acc) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));

    if (!rst && ((req_ready & req_valid) != 2'b00)) begin
      obs_id.push_back(req_ready[1] ? 1 : 0);
      obs_cyc.push_back(cyc);
    end

    if (rst) begin
      pend.delete();
      ptr = 0;
    end else begin
      if (in_resp && rsp_ready) void'(pend.pop_front());
      if (g >= 0) begin
        it.id  = g;
        it.op  = req_op[4*g +: 4];
        it.a   = req_a[N*g +: N];
        it.b   = req_b[N*g +: N];
        it.acc = cyc;
        pend.push_back(it);
        ptr = (g + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] op0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic [3:0] op1, input logic [31:0] a1,
                               input logic [31:0] b1, input logic rready, input logic rst_in);
    @(negedge clk);
    rst       = rst_in;
    req_valid = valid;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rready;
    #1;
    modelCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int          n0;
    int          seen0;
    logic [3:0]  rop [2];
    logic [3:0]  opts [5];
    total = 0; bad = 0; cyc = 0; ptr = 0; rsp_seen = 0;
    last_res = '0; last_zero = 1'b0; last_ill = 1'b0; last_valid = '0;
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    opts[0] = 4'b0010; opts[1] = 4'b0110; opts[2] = 4'b0000; opts[3] = 4'b0001; opts[4] = 4'b1111;

    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b0, 1'b1);
    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b0, 1'b1);
    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b0, 1'b0);
    checkOutput("reset_result", 64'(rsp_result), 64'd0);
    checkOutput("reset_zero", 64'(rsp_zero), 64'd0);
    checkOutput("reset_illegal", 64'(rsp_illegal), 64'd0);

    // 1: ADD 5+7 from req0
    applyStimulus(2'b01, 4'b0010, 32'd5, 32'd7, 4'h0, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b1, 1'b0);
    checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("t1_result", 64'(rsp_result), 64'd12);
    checkOutput("t1_zero", 64'(rsp_zero), 64'd0);
    idleCycles(2);

    // 2: SUB results at zero and at wrap-around
    applyStimulus(2'b01, 4'b0110, 32'd9, 32'd9, 4'h0, 0, 0, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("t2_sub_zero_res", 64'(last_res), 64'd0);
    checkOutput("t2_sub_zero_flag", 64'(last_zero), 64'd1);
    applyStimulus(2'b01, 4'b0110, 32'd0, 32'd1, 4'h0, 0, 0, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("t2_sub_wrap_res", 64'(last_res), 64'hFFFF_FFFF);
    checkOutput("t2_sub_wrap_flag", 64'(last_zero), 64'd0);

    // 5: illegal op from req1
    applyStimulus(2'b10, 4'h0, 0, 0, 4'b1111, 32'h1234, 32'h5678, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("t5_valid", 64'(last_valid), 64'h2);
    checkOutput("t5_result", 64'(last_res), 64'd0);
    checkOutput("t5_zero", 64'(last_zero), 64'd1);
    checkOutput("t5_illegal", 64'(last_ill), 64'd1);

    // 3: both requesters continuously valid
    obs_id.delete(); obs_cyc.delete();
    for (int i = 0; i < 8; i++)
      applyStimulus(2'b11, 4'b0010, 32'(i), 32'd1, 4'b0001, 32'(i), 32'h100, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("t3_accepts", 64'(obs_id.size()), 64'd4);
    if (obs_id.size() >= 4) begin
      checkOutput("t3_grant0", 64'(obs_id[0]), 64'd0);
      checkOutput("t3_grant1", 64'(obs_id[1]), 64'd1);
      checkOutput("t3_grant2", 64'(obs_id[2]), 64'd0);
      checkOutput("t3_grant3", 64'(obs_id[3]), 64'd1);
      checkOutput("t3_spacing", 64'(obs_cyc[3] - obs_cyc[0]), 64'd6);
    end

    // 4: response backpressure
    applyStimulus(2'b01, 4'b0000, 32'hFF00, 32'h0FF0, 4'h0, 0, 0, 1'b1, 1'b0);
    applyStimulus(2'b11, 4'b0010, 1, 1, 4'b0010, 2, 2, 1'b0, 1'b0);
    obs_id.delete(); obs_cyc.delete();
    for (int i = 0; i < 5; i++)
      applyStimulus(2'b11, 4'b0010, 1, 1, 4'b0010, 2, 2, 1'b0, 1'b0);
    checkOutput("t4_no_accept", 64'(obs_id.size()), 64'd0);
    checkOutput("t4_result_held", 64'(rsp_result), 64'h0000_0F00);
    idleCycles(4);

    // 6: reset during EXEC of AND from req0
    applyStimulus(2'b01, 4'b0000, 32'hF0, 32'h3C, 4'h0, 0, 0, 1'b1, 1'b0);
    seen0 = rsp_seen;
    applyStimulus(2'b00, 4'h0, 0, 0, 4'h0, 0, 0, 1'b1, 1'b1);
    idleCycles(4);
    checkOutput("t6_no_rsp", 64'(rsp_seen - seen0), 64'd0);
    obs_id.delete(); obs_cyc.delete();
    applyStimulus(2'b11, 4'b0010, 3, 4, 4'b0010, 5, 6, 1'b1, 1'b0);
    n0 = obs_id.size();
    checkOutput("t6_accept", 64'(n0), 64'd1);
    if (n0 >= 1) checkOutput("t6_req0_wins", 64'(obs_id[0]), 64'd0);
    idleCycles(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rop[0] = opts[$urandom_range(0, 4)];
      rop[1] = opts[$urandom_range(0, 4)];
      if (rop[0] == 4'b1111) rop[0] = 4'($urandom_range(0, 15));
      applyStimulus(2'($urandom_range(0, 3)), rop[0], $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                    rop[1], $urandom, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end
    idleCycles(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
